// File: rtl/param_up_down_counter.sv
// rtl/param_up_down_counter.sv - parametrised modulo/saturating up/down counter with load and wrap pulse
//
// Purpose : WIDTH-bit up/down counter, modulo MAX_VAL+1, stepping by STEP.
//           It has a count enable, a parallel load that clamps out-of-range
//           values, combinational terminal-count decodes and a registered
//           one-cycle wrap pulse.
// Build   : define UPDOWN_SATURATE_EN to saturate at 0/MAX_VAL instead of wrapping.
//           In that build, wrap_o pulses when a count request is blocked or
//           clipped at a limit.
// Ports   : clk_i      rising-edge clock
//           rst_ni     asynchronous active-low reset
//           en_i       count enable (gates up/down, not load)
//           load_i     synchronous load of value_i (highest priority)
//           up_i       count up by STEP
//           down_i     count down by STEP
//           value_i    load data [WIDTH-1:0]
//           count_o    registered count [WIDTH-1:0]
//           at_max_o   count_o == MAX_VAL
//           at_zero_o  count_o == 0
//           wrap_o     registered 1-cycle boundary pulse
module param_up_down_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int STEP    = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_max_o,
  output logic             at_zero_o,
  output logic             wrap_o
);

  // One guard bit so count+STEP and count+MOD never overflow when MAX_VAL = 2**WIDTH-1.
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MOD_X  = MAX_X + (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   value_x;
  logic [WIDTH:0]   sum_x;
  logic             do_up;
  logic             do_down;

  assign count_x = {1'b0, count_q};
  assign value_x = {1'b0, value_i};
  assign sum_x   = count_x + STEP_X;
  assign do_up   = en_i & up_i & ~down_i;
  assign do_down = en_i & down_i & ~up_i;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = (value_x > MAX_X) ? MAX_W : value_i;
    end else if (do_up) begin
      if (sum_x > MAX_X) begin
        wrap_d = 1'b1;
`ifdef UPDOWN_SATURATE_EN
        count_d = MAX_W;
`else
        count_d = WIDTH'(sum_x - MOD_X);
`endif
      end else begin
        count_d = WIDTH'(sum_x);
      end
    end else if (do_down) begin
      if (count_x < STEP_X) begin
        wrap_d = 1'b1;
`ifdef UPDOWN_SATURATE_EN
        count_d = '0;
`else
        // count < STEP here, so count + MOD - STEP stays below MOD.
        count_d = WIDTH'(count_x + MOD_X - STEP_X);
`endif
      end else begin
        count_d = WIDTH'(count_x - STEP_X);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o   = count_q;
  assign wrap_o    = wrap_q;
  assign at_max_o  = (count_q == MAX_W);
  assign at_zero_o = (count_q == '0);

endmodule
